hpdcache_sram_arbiter: RTL

Two-requester controller for one single-port (1RW) cache SRAM macro with one-cycle read latency. Zero-fills the whole array after reset or on request, then shares the port between a refill requester (A) and a core requester (B) using round-robin arbitration with valid/ready handshakes. It returns read data to the winning requester one cycle after the grant. It sits between the HPDcache data/directory control logic and the SRAM wrapper instance.

---
 rtl/hpdcache_sram_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hpdcache_sram_arbiter.sv
// ---------------------------------------------------------------------------
// hpdcache_sram_arbiter
//
// Purpose:
//   Front-end controller for a single-port (1RW) cache SRAM macro with a
//   one-cycle read latency. After reset, or when init_req_i is pulsed, it
//   writes zero to every word of the array. Once the array is clean, it
//   shares the SRAM port between a refill requester (A) and a core
//   requester (B). Arbitration is round-robin, and each requester uses a
//   valid/ready handshake. Read data goes back to the requester that won
//   the access, one cycle after its grant.
//
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   init_req_i                  restart the zero-fill sweep (RUN only)
//   init_done_o                 array initialised, requests may be granted
//   {a,b}_req_valid_i           request valid
//   {a,b}_req_ready_o           request granted this cycle
//   {a,b}_req_we_i              1 = write, 0 = read
//   {a,b}_req_addr_i            word address
//   {a,b}_req_wdata_i           write data
//   {a,b}_rsp_valid_o           read response valid (no backpressure)
//   {a,b}_rsp_rdata_o           read response data (0 when not valid)
//   sram_cs_o, sram_we_o        SRAM chip select / write enable
//   sram_addr_o, sram_wdata_o   SRAM address / write data
//   sram_rdata_i                SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module hpdcache_sram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 256,
  parameter int DEPTH     = 2 ** ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 init_req_i,
  output logic                 init_done_o,

  input  logic                 a_req_valid_i,
  output logic                 a_req_ready_o,
  input  logic                 a_req_we_i,
  input  logic [ADDR_SIZE-1:0] a_req_addr_i,
  input  logic [DATA_SIZE-1:0] a_req_wdata_i,
  output logic                 a_rsp_valid_o,
  output logic [DATA_SIZE-1:0] a_rsp_rdata_o,

  input  logic                 b_req_valid_i,
  output logic                 b_req_ready_o,
  input  logic                 b_req_we_i,
  input  logic [ADDR_SIZE-1:0] b_req_addr_i,
  input  logic [DATA_SIZE-1:0] b_req_wdata_i,
  output logic                 b_rsp_valid_o,
  output logic [DATA_SIZE-1:0] b_rsp_rdata_o,

  output logic                 sram_cs_o,
  output logic                 sram_we_o,
  output logic [ADDR_SIZE-1:0] sram_addr_o,
  output logic [DATA_SIZE-1:0] sram_wdata_o,
  input  logic [DATA_SIZE-1:0] sram_rdata_i
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The last word written by the sweep. The sweep stops here, so the
  // counter never wraps, even when DEPTH < 2**ADDR_SIZE.
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  state_e                 state_reg, state_next;
  logic [ADDR_SIZE-1:0]   cnt_reg, cnt_next;
  logic                   ptr_reg, ptr_next;      // 0 = A has priority, 1 = B
  logic                   a_rsp_valid_reg, b_rsp_valid_reg;
  logic                   grant_a, grant_b;

  // -------------------------------------------------------------------------
  // Next-state, arbitration and SRAM drive
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ptr_next     = ptr_reg;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;

    case (state_reg)
      INIT: begin
        // While the sweep runs, the SRAM port is owned by the zero-fill
        // sweep and init_req_i is ignored.
        sram_cs_o   = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = cnt_reg;
        if (cnt_reg == LAST_ADDR) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RUN: begin
        if (init_req_i) begin
          // Nothing is granted in the cycle the restart is seen, so no
          // request races the new sweep.
          state_next = INIT;
          cnt_next   = '0;
        end else begin
          // The pointer only decides when both ports are valid. Ready comes
          // only from valid and the pointer, never from the other ready.
          grant_a = a_req_valid_i & (~b_req_valid_i | ~ptr_reg);
          grant_b = b_req_valid_i & ~grant_a;

          if (grant_a) begin
            sram_cs_o    = 1'b1;
            sram_we_o    = a_req_we_i;
            sram_addr_o  = a_req_addr_i;
            sram_wdata_o = a_req_wdata_i;
            ptr_next     = 1'b1;
          end else if (grant_b) begin
            sram_cs_o    = 1'b1;
            sram_we_o    = b_req_we_i;
            sram_addr_o  = b_req_addr_i;
            sram_wdata_o = b_req_wdata_i;
            ptr_next     = 1'b0;
          end
        end
      end

      default: begin
        state_next = INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, sweep counter, round-robin pointer and response flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= INIT;
      cnt_reg         <= '0;
      ptr_reg         <= 1'b0;
      a_rsp_valid_reg <= 1'b0;
      b_rsp_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      ptr_reg         <= ptr_next;
      a_rsp_valid_reg <= grant_a & ~a_req_we_i;
      b_rsp_valid_reg <= grant_b & ~b_req_we_i;
    end
  end

  assign init_done_o   = (state_reg == RUN);
  assign a_req_ready_o = grant_a;
  assign b_req_ready_o = grant_b;

  // Read data comes straight from the macro. It is only exposed in the
  // cycle the requester owns it.
  assign a_rsp_valid_o = a_rsp_valid_reg;
  assign b_rsp_valid_o = b_rsp_valid_reg;
  assign a_rsp_rdata_o = a_rsp_valid_reg ? sram_rdata_i : '0;
  assign b_rsp_rdata_o = b_rsp_valid_reg ? sram_rdata_i : '0;

endmodule
